// File: rtl/ring_sequence_decoder.sv
// Ring-counter sequence decoder.
// Decodes one-hot codes, tracks ring order, counts errors.
module ring_sequence_decoder #(
  parameter int NBITS_COUNT = 4,
  parameter int IDX_W = $clog2(NBITS_COUNT),
  parameter int LOCK_CNT = 3,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [NBITS_COUNT-1:0] Code_in,
  input  logic                   clear_err,
  output logic [IDX_W-1:0]       Index,
  output logic                   index_valid,
  output logic                   illegal,
  output logic                   seq_err,
  output logic                   locked,
  output logic [ERR_W-1:0]       err_count
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT,
    TRACK,
    LOCKED
  } state_t;

  state_t                 state;
  logic [NBITS_COUNT-1:0] expected;
  logic [GC_W-1:0]        good_cnt;

  logic                   legal;
  logic                   hit;
  logic [IDX_W-1:0]       enc;
  logic [NBITS_COUNT-1:0] rot;
  logic [GC_W-1:0]        gc_inc;
  logic                   err_ev;

  assign legal  = $onehot(Code_in);
  assign hit    = (Code_in == expected);
  assign gc_inc = good_cnt + GC_W'(1);
  assign rot    = {Code_in[NBITS_COUNT-2:0],
                   Code_in[NBITS_COUNT-1]};

  // Error event: bad code, or ring break while locked
  assign err_ev = valid &
                  (!legal ||
                   (state == LOCKED && !hit));

  // Priority-free encoder; only used for one-hot codes
  always_comb begin
    enc = '0;
    for (int i = 0; i < NBITS_COUNT; i++) begin
      if (Code_in[i]) enc = IDX_W'(i);
    end
  end

  // Sequence FSM with registered index and pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      expected    <= '0;
      good_cnt    <= '0;
      Index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      if (valid) begin
        if (!legal) begin
          illegal  <= 1'b1;
          state    <= HUNT;
          locked   <= 1'b0;
          good_cnt <= '0;
        end else begin
          index_valid <= 1'b1;
          Index       <= enc;
          expected    <= rot;
          unique case (state)
            HUNT: begin
              state    <= TRACK;
              good_cnt <= '0;
            end
            TRACK: begin
              if (hit) begin
                good_cnt <= gc_inc;
                if (gc_inc == GC_W'(LOCK_CNT)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!hit) begin
                seq_err  <= 1'b1;
                state    <= TRACK;
                good_cnt <= '0;
                locked   <= 1'b0;
              end
            end
            default: begin
              state    <= HUNT;
              good_cnt <= '0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Saturating error counter; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (err_ev && err_count != '1) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_sequence_decoder.sv
// Bench for ring_sequence_decoder.
// Index-arithmetic model plus directed literal checks.
module tb_ring_sequence_decoder;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int LC = 3;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic [N-1:0]  Code_in;
  logic          clear_err;
  logic [IW-1:0] Index;
  logic          index_valid;
  logic          illegal;
  logic          seq_err;
  logic          locked;
  logic [EW-1:0] err_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ring_sequence_decoder #(
    .NBITS_COUNT(N),
    .IDX_W(IW),
    .LOCK_CNT(LC),
    .ERR_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .Code_in(Code_in),
    .clear_err(clear_err),
    .Index(Index),
    .index_valid(index_valid),
    .illegal(illegal),
    .seq_err(seq_err),
    .locked(locked),
    .err_count(err_count)
  );

  function automatic void chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  nm, act, exp, $time);
  endfunction

  // Model: run = correct steps since last reference, -1 = none
  int m_idx, m_iv, m_ill, m_seq, m_lock, m_err;
  int run, prev, k;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_idx = 0; m_iv = 0; m_ill = 0; m_seq = 0;
      m_lock = 0; m_err = 0; run = -1; prev = 0;
    end else begin
      m_iv = 0; m_ill = 0; m_seq = 0;
      if (valid) begin
        if ($countones(Code_in) != 1) begin
          m_ill = 1; run = -1; m_lock = 0; m_err++;
        end else begin
          k = $clog2(Code_in);
          m_iv = 1; m_idx = k;
          if (run < 0) begin
            run = 0;
          end else if (k == (prev + 1) % N) begin
            run++;
            if (run >= LC) m_lock = 1;
          end else begin
            if (m_lock == 1) begin
              m_seq = 1; m_err++;
            end
            m_lock = 0; run = 0;
          end
          prev = k;
        end
      end
      if (m_err > (1 << EW) - 1) m_err = (1 << EW) - 1;
      if (clear_err) m_err = 0;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("m.Index", int'(Index), m_idx);
    chk("m.index_valid", int'(index_valid), m_iv);
    chk("m.illegal", int'(illegal), m_ill);
    chk("m.seq_err", int'(seq_err), m_seq);
    chk("m.locked", int'(locked), m_lock);
    chk("m.err_count", int'(err_count), m_err);
  end

  task automatic st(input logic v,
                    input logic [N-1:0] c,
                    input logic clr);
    @(negedge clk);
    valid = v; Code_in = c; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] bad [8];

  initial begin
    bad = '{4'd0, 4'd3, 4'd5, 4'd6,
            4'd7, 4'd9, 4'd12, 4'd15};
    reset = 1'b0; valid = 1'b0;
    Code_in = '0; clear_err = 1'b0;
    #12;
    chk("rst.Index", int'(Index), 0);
    chk("rst.locked", int'(locked), 0);
    chk("rst.err", int'(err_count), 0);
    @(negedge clk); #1 reset = 1'b1;

    // 1: first pass through the ring, lock on code 8
    st(1, 4'd1, 0);
    chk("t1.iv0", int'(index_valid), 1);
    chk("t1.idx0", int'(Index), 0);
    st(1, 4'd2, 0);
    chk("t1.idx1", int'(Index), 1);
    st(1, 4'd4, 0);
    chk("t1.idx2", int'(Index), 2);
    chk("t1.nolock", int'(locked), 0);
    st(1, 4'd8, 0);
    chk("t1.idx3", int'(Index), 3);
    chk("t1.lock", int'(locked), 1);
    chk("t1.err", int'(err_count), 0);

    // idle cycle: pulses drop, state held
    st(0, 4'd5, 0);
    chk("idle.iv", int'(index_valid), 0);
    chk("idle.ill", int'(illegal), 0);
    chk("idle.lock", int'(locked), 1);

    // 2: wrap 8 -> 1 while locked
    st(1, 4'd1, 0);
    st(1, 4'd2, 0);
    st(1, 4'd4, 0);
    st(1, 4'd8, 0);
    chk("t2.idx3", int'(Index), 3);
    st(1, 4'd1, 0);
    chk("t2.idx0", int'(Index), 0);
    chk("t2.lock", int'(locked), 1);
    chk("t2.seq", int'(seq_err), 0);

    // 3: break the ring at 2 -> 8, then relock
    st(1, 4'd2, 0);
    st(1, 4'd8, 0);
    chk("t3.seq", int'(seq_err), 1);
    chk("t3.lock", int'(locked), 0);
    chk("t3.err", int'(err_count), 1);
    chk("t3.idx", int'(Index), 3);
    st(1, 4'd1, 0);
    chk("t3.seqlow", int'(seq_err), 0);
    st(1, 4'd2, 0);
    chk("t3.nolock", int'(locked), 0);
    st(1, 4'd4, 0);
    chk("t3.relock", int'(locked), 1);

    // 4: illegal zero and multi-hot codes
    st(1, 4'd0, 0);
    chk("t4.ill0", int'(illegal), 1);
    chk("t4.idx0", int'(Index), 2);
    chk("t4.lock", int'(locked), 0);
    st(1, 4'd6, 0);
    chk("t4.ill6", int'(illegal), 1);
    chk("t4.err", int'(err_count), 3);
    st(1, 4'd4, 0);
    chk("t4.iv", int'(index_valid), 1);
    chk("t4.idx", int'(Index), 2);
    chk("t4.lock2", int'(locked), 0);

    // 5: saturate, then clear against an illegal code
    for (int i = 0; i < 300; i++) st(1, bad[i % 8], 0);
    chk("t5.sat", int'(err_count), 255);
    st(1, 4'd0, 1);
    chk("t5.clr", int'(err_count), 0);
    chk("t5.ill", int'(illegal), 1);

    // 6: async reset while locked
    st(1, 4'd1, 0);
    st(1, 4'd2, 0);
    st(1, 4'd4, 0);
    st(1, 4'd8, 0);
    chk("t6.lock", int'(locked), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6.idx", int'(Index), 0);
    chk("t6.iv", int'(index_valid), 0);
    chk("t6.lock0", int'(locked), 0);
    chk("t6.err", int'(err_count), 0);
    @(negedge clk); #1 reset = 1'b1;
    st(1, 4'd4, 0);
    chk("t6.idx2", int'(Index), 2);
    chk("t6.iv2", int'(index_valid), 1);
    chk("t6.nolock", int'(locked), 0);

    st(0, 4'd0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
